microc_seq: RTL and testbench
=============================

// Module: microc_seq
// PURPOSE
//   Instruction sequencer for the microc datapath: the datapath-side end of the uc control interface.
//   Holds the PC, a return-address stack for call/ret and the registered zero flag.
//   Accepts s_inc/wez/call/ret/halt from uc and returns opcode and zero to uc.
//   Sits between program memory (combinational read at pc) and uc; single-cycle machine.
// PARAMETERS
//   PC_W        10  program counter / address width (program memory depth 2**PC_W)
//   INSTR_W     16  instruction word width; opcode is instr[INSTR_W-1 -: OPC_W]
//   OPC_W        6  opcode width presented to uc
//   STACK_DEPTH  4  return-address stack entries (power of two, >=2)
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high reset
//   instr      in   INSTR_W  program memory data at address pc (same cycle)
//   jmp_addr   in   PC_W     branch/call target from instruction field
//   s_inc      in   1        1: pc<=pc+1; 0: pc<=jmp_addr (ignored when call/ret/halt)
//   s_call     in   1        push pc+1, jump to jmp_addr
//   s_ret      in   1        pop return address into pc
//   s_halt     in   1        hold pc, no stack change
//   wez        in   1        write-enable for zero flag
//   alu_zero   in   1        ALU result==0 this cycle
//   pc         out  PC_W     current program counter (registered)
//   opcode     out  OPC_W    instr upper OPC_W bits, combinational
//   zero       out  1        registered zero flag to uc
//   stack_ovf  out  1        sticky: call attempted with stack full
//   stack_unf  out  1        sticky: ret attempted with stack empty
// BEHAVIOUR
//   - Reset (clk edge with reset=1): pc=0, zero=0, sp=0, stack_ovf=0, stack_unf=0; stack contents don't-care.
//     Reset mid-call sequence discards all stacked addresses.
//   - opcode = instr[INSTR_W-1 -: OPC_W], zero latency from instr.
//   - Next-pc priority per edge: s_halt > s_ret > s_call > s_inc.
//     halt: pc holds; call/ret/wez still sampled? No: halt blocks stack ops; wez still honoured.
//     ret:  sp>0 -> pc<=stack[sp-1], sp<=sp-1; sp==0 -> pc<=pc+1, stack_unf<=1.
//     call: sp<DEPTH -> stack[sp]<=pc+1, sp<=sp+1, pc<=jmp_addr;
//           sp==DEPTH -> pc<=jmp_addr, no push, stack_ovf<=1 (existing entries preserved).
//     s_call&s_ret same cycle: ret wins, call ignored, no flag.
//     else s_inc=1 -> pc+1, s_inc=0 -> jmp_addr.
//   - pc+1 is modulo 2**PC_W: pc=2**PC_W-1 -> 0; pushed return address wraps identically.
//   - zero<=alu_zero on edge when wez=1, else holds. Independent of halt/stack.
//   - Flags sticky until reset. sp width clog2(DEPTH)+1; sp ranges 0..DEPTH.
//   - Latency: control inputs take effect on pc one edge later; opcode follows next cycle.
// STRUCTURE
//   - Package microc_pkg: PC_W, INSTR_W, OPC_W defaults; opcode localparams shared with uc.
//   - One sub-module: microc_ras (LIFO: push, pop, data_in, top, full, empty, sync reset).
//   - Next-pc mux and zero flag stay in microc_seq.
// TESTING
//   1 reset then s_inc=1 for 5 cycles -> pc 0,1,2,3,4,5; opcode tracks instr[15:10].
//   2 at pc=3 s_inc=0 jmp_addr=0x2A -> pc=0x2A next edge; pc=0x3FF,s_inc=1 -> pc=0.
//   3 call 0x100 at pc=7, call 0x200, ret, ret -> pc 0x100,0x200,0x101,0x008; sp back to 0.
//   4 5 calls (DEPTH=4) -> stack_ovf=1 on 5th, pc=target; 4 rets return correct addrs;
//     5th ret -> stack_unf=1, pc+1.
//   5 wez=1 alu_zero=1 -> zero=1 next edge; wez=0 alu_zero=0 -> zero stays 1; halt holds pc.
//   6 reset asserted with sp=3 -> pc=0, sp=0, flags 0; following ret sets stack_unf.

Source files
------------

// File: rtl/microc_pkg.sv
// Shared definitions for the microc datapath sequencer and the uc controller.
package microc_pkg;

  localparam int DEFAULT_PC_W        = 10;
  localparam int DEFAULT_INSTR_W     = 16;
  localparam int DEFAULT_OPC_W       = 6;
  localparam int DEFAULT_STACK_DEPTH = 4;

  // Opcode map decoded by uc; the sequencer only forwards the field.
  typedef enum logic [DEFAULT_OPC_W-1:0] {
    OPC_NOP  = 6'h00,
    OPC_LDI  = 6'h01,
    OPC_ADD  = 6'h02,
    OPC_SUB  = 6'h03,
    OPC_AND  = 6'h04,
    OPC_OR   = 6'h05,
    OPC_JMP  = 6'h10,
    OPC_JZ   = 6'h11,
    OPC_JNZ  = 6'h12,
    OPC_CALL = 6'h18,
    OPC_RET  = 6'h19,
    OPC_HALT = 6'h3F
  } opcode_e;

  // Source of the next program counter value.
  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_JMP,
    PC_POP
  } pc_sel_e;

endpackage

// File: rtl/microc_seq_if.sv
// Control interface between uc (master) and the datapath sequencer (slave).
interface microc_seq_if
  import microc_pkg::*;
#(
  parameter int OPC_W = DEFAULT_OPC_W
);

  logic             s_inc;
  logic             s_call;
  logic             s_ret;
  logic             s_halt;
  logic             wez;
  logic [OPC_W-1:0] opcode;
  logic             zero;

  modport master (
    output s_inc, s_call, s_ret, s_halt, wez,
    input  opcode, zero
  );

  modport slave (
    input  s_inc, s_call, s_ret, s_halt, wez,
    output opcode, zero
  );

endinterface

// File: rtl/microc_ras.sv
// Return-address stack: LIFO with occupancy count 0..DEPTH; push when full
// and pop when empty are ignored so the caller can flag them.
module microc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           data_in,
  output logic [W-1:0]           top,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] sp
);

  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [SP_W-1:0] sp_q, sp_d;
  logic [SP_W-1:0] sp_m1;
  logic            wr_en;

  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);
  assign wr_en = push && !full;
  assign sp_m1 = sp_q - 1'b1;
  assign top   = mem_q[sp_m1[AW-1:0]];
  assign sp    = sp_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sp_d = sp_q;
    if (wr_en) begin
      sp_d = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[sp_q[AW-1:0]] <= data_in;
    end
  end

endmodule

// File: rtl/microc_seq.sv
// Instruction sequencer: PC, next-pc selection, return-address stack and
// registered zero flag for the single-cycle microc machine.
module microc_seq
  import microc_pkg::*;
#(
  parameter int PC_W        = DEFAULT_PC_W,
  parameter int INSTR_W     = DEFAULT_INSTR_W,
  parameter int OPC_W       = DEFAULT_OPC_W,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  microc_seq_if.slave        uc,
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    jmp_addr,
  input  logic               alu_zero,
  output logic [PC_W-1:0]    pc,
  output logic               stack_ovf,
  output logic               stack_unf
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;
  logic            ras_full, ras_empty;
  logic            ras_push, ras_pop;
  logic [$clog2(STACK_DEPTH):0] ras_sp;
  pc_sel_e         pc_sel;

  // Natural width truncation gives the required wrap at 2**PC_W-1.
  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    pc_sel   = PC_HOLD;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    zero_d   = uc.wez ? alu_zero : zero_q;

    // Halt blocks every stack operation; ret beats a simultaneous call.
    if (uc.s_halt) begin
      pc_sel = PC_HOLD;
    end else if (uc.s_ret) begin
      if (!ras_empty) begin
        pc_sel  = PC_POP;
        ras_pop = 1'b1;
      end else begin
        pc_sel = PC_INC;
        unf_d  = 1'b1;
      end
    end else if (uc.s_call) begin
      pc_sel = PC_JMP;
      if (!ras_full) begin
        ras_push = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      pc_sel = uc.s_inc ? PC_INC : PC_JMP;
    end

    unique case (pc_sel)
      PC_HOLD: pc_d = pc_q;
      PC_INC:  pc_d = pc_inc;
      PC_JMP:  pc_d = jmp_addr;
      PC_POP:  pc_d = ras_top;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  microc_ras #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (ras_push),
    .pop     (ras_pop),
    .data_in (pc_inc),
    .top     (ras_top),
    .full    (ras_full),
    .empty   (ras_empty),
    .sp      (ras_sp)
  );

  assign uc.opcode = instr[INSTR_W-1 -: OPC_W];
  assign uc.zero   = zero_q;
  assign pc        = pc_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_microc_seq.sv
// Self-checking bench for microc_seq: directed scenarios then random control
// traffic, compared against a queue-based reference model.
module tb_microc_seq;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 16;
  localparam int OPC_W   = 6;
  localparam int DEPTH   = 4;
  localparam int PC_MOD  = 1 << PC_W;

  logic               clk = 1'b0;
  logic               reset;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    jmp_addr;
  logic               alu_zero;
  logic [PC_W-1:0]    pc;
  logic               stack_ovf;
  logic               stack_unf;

  microc_seq_if #(.OPC_W(OPC_W)) uc_bus ();

  microc_seq #(
    .PC_W        (PC_W),
    .INSTR_W     (INSTR_W),
    .OPC_W       (OPC_W),
    .STACK_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uc        (uc_bus),
    .instr     (instr),
    .jmp_addr  (jmp_addr),
    .alu_zero  (alu_zero),
    .pc        (pc),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          m_pc;
  int unsigned m_stack [$];
  bit          m_zero, m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_pc = 0;
      m_stack.delete();
      m_zero = 0;
      m_ovf  = 0;
      m_unf  = 0;
      return;
    end
    if (uc_bus.wez) m_zero = alu_zero;
    if (uc_bus.s_halt) begin
      // pc and stack untouched
    end else if (uc_bus.s_ret) begin
      if (m_stack.size() > 0) begin
        m_pc = int'(m_stack.pop_back());
      end else begin
        m_pc  = (m_pc + 1) % PC_MOD;
        m_unf = 1;
      end
    end else if (uc_bus.s_call) begin
      if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % PC_MOD);
      else m_ovf = 1;
      m_pc = int'(jmp_addr);
    end else begin
      m_pc = uc_bus.s_inc ? (m_pc + 1) % PC_MOD : int'(jmp_addr);
    end
  endtask

  // One clock: advance model with current inputs, then compare after the edge.
  task automatic step(input string tag);
    logic [INSTR_W-1:0] ins;
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "_pc"},   32'(pc),              32'(m_pc));
    check({tag, "_zero"}, 32'(uc_bus.zero),     32'(m_zero));
    check({tag, "_ovf"},  32'(stack_ovf),       32'(m_ovf));
    check({tag, "_unf"},  32'(stack_unf),       32'(m_unf));
    check({tag, "_sp"},   32'(dut.u_ras.sp_q),  32'(m_stack.size()));
    ins   = 16'($urandom);
    instr = ins;
    #1;
    check({tag, "_opc"},  32'(uc_bus.opcode),   32'(ins >> (INSTR_W - OPC_W)));
  endtask

  task automatic ctrl(input bit inc, input bit call, input bit ret, input bit halt);
    uc_bus.s_inc  = inc;
    uc_bus.s_call = call;
    uc_bus.s_ret  = ret;
    uc_bus.s_halt = halt;
  endtask

  initial begin
    int held;
    int ret_pc [4];
    ret_pc = '{32'h031, 32'h021, 32'h011, 32'h009};

    reset = 1'b1;
    instr = '0;
    jmp_addr = '0;
    alu_zero = 1'b0;
    uc_bus.wez = 1'b0;
    ctrl(1, 0, 0, 0);
    m_pc = 0;
    step("rst0");
    step("rst1");
    check("rst_pc", 32'(pc), 32'h0);

    // 1: sequential fetch
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step("t1");
      check("t1_pc_lit", 32'(pc), 32'(i));
    end

    // 2: jump and pc wrap
    ctrl(0, 0, 0, 0);
    jmp_addr = 10'h003; step("t2a");
    jmp_addr = 10'h02A; step("t2b");
    check("t2_jmp", 32'(pc), 32'h02A);
    jmp_addr = 10'h3FF; step("t2c");
    ctrl(1, 0, 0, 0);   step("t2d");
    check("t2_wrap", 32'(pc), 32'h000);

    // 3: nested call/ret
    ctrl(0, 0, 0, 0); jmp_addr = 10'h007; step("t3a");
    ctrl(1, 1, 0, 0); jmp_addr = 10'h100; step("t3b");
    check("t3_call1", 32'(pc), 32'h100);
    jmp_addr = 10'h200; step("t3c");
    check("t3_call2", 32'(pc), 32'h200);
    ctrl(1, 0, 1, 0); step("t3d");
    check("t3_ret1", 32'(pc), 32'h101);
    step("t3e");
    check("t3_ret2", 32'(pc), 32'h008);
    check("t3_sp", 32'(dut.u_ras.sp_q), 32'h0);

    // 4: overflow on 5th call, underflow on 5th ret
    ctrl(1, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      jmp_addr = PC_W'(k * 16);
      step("t4c");
    end
    check("t4_ovf", 32'(stack_ovf), 32'h1);
    check("t4_tgt", 32'(pc), 32'h050);
    ctrl(1, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step("t4r");
      check("t4_ret_lit", 32'(pc), 32'(ret_pc[k]));
    end
    step("t4u");
    check("t4_unf", 32'(stack_unf), 32'h1);
    check("t4_unf_pc", 32'(pc), 32'h00A);

    // 5: zero flag and halt
    ctrl(1, 0, 0, 0); uc_bus.wez = 1'b1; alu_zero = 1'b1; step("t5a");
    check("t5_zero_set", 32'(uc_bus.zero), 32'h1);
    uc_bus.wez = 1'b0; alu_zero = 1'b0; step("t5b");
    check("t5_zero_hold", 32'(uc_bus.zero), 32'h1);
    held = m_pc;
    ctrl(1, 1, 0, 1); jmp_addr = 10'h055; step("t5c");
    uc_bus.wez = 1'b1; step("t5d");
    check("t5_halt_pc", 32'(pc), 32'(held));
    check("t5_halt_zero", 32'(uc_bus.zero), 32'h0);
    uc_bus.wez = 1'b0;

    // 6: reset with live stack entries
    ctrl(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      jmp_addr = PC_W'(10'h0C0 + k);
      step("t6c");
    end
    check("t6_sp3", 32'(dut.u_ras.sp_q), 32'h3);
    reset = 1'b1; step("t6r");
    check("t6_rst_sp", 32'(dut.u_ras.sp_q), 32'h0);
    check("t6_rst_flags", 32'({stack_ovf, stack_unf}), 32'h0);
    reset = 1'b0; ctrl(1, 0, 1, 0); step("t6u");
    check("t6_unf", 32'(stack_unf), 32'h1);
    check("t6_unf_pc", 32'(pc), 32'h001);

    // Random control traffic
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 59) == 0);
      uc_bus.s_halt = ($urandom_range(0, 9) == 0);
      uc_bus.s_ret  = ($urandom_range(0, 4) == 0);
      uc_bus.s_call = ($urandom_range(0, 3) == 0);
      uc_bus.s_inc  = ($urandom_range(0, 3) != 0);
      uc_bus.wez    = 1'($urandom);
      alu_zero      = 1'($urandom);
      jmp_addr      = PC_W'($urandom);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
